// File: rtl/prbs31_checker_if.sv
`default_nettype none
// ============================================================================
// Module   : prbs31_checker_if
// Brief    : Serial data/status bundle between a PRBS31 checker and its host.
// Revision : 1.0
// ============================================================================
interface prbs31_checker_if #(
  parameter int ERR_W = 16,
  parameter int BIT_W = 32
);
  logic             din;
  logic             din_valid;
  logic             clr_cnt;
  logic             locked;
  logic             err_pulse;
  logic [ERR_W-1:0] err_count;
  logic [BIT_W-1:0] bit_count;

  modport master (
    output din, din_valid, clr_cnt,
    input  locked, err_pulse, err_count, bit_count
  );

  modport slave (
    input  din, din_valid, clr_cnt,
    output locked, err_pulse, err_count, bit_count
  );
endinterface
`default_nettype wire

// File: rtl/prbs31_checker.sv
`default_nettype none
// ============================================================================
// Module   : prbs31_checker
// Brief    : Self-synchronising PRBS31 (x^31 + x^28 + 1) serial checker with
//            lock detection, error pulse and saturating error/bit counters.
// Revision : 1.0
// ============================================================================
module prbs31_checker #(
  parameter int LOCK_COUNT  = 64,
  parameter int LOSS_WINDOW = 256,
  parameter int LOSS_THRESH = 8,
  parameter int ERR_W       = 16,
  parameter int BIT_W       = 32
) (
  input  wire logic          clk,
  input  wire logic          rst_n,
  prbs31_checker_if.slave    bus
);

  localparam int WIN_W  = (LOSS_WINDOW > 2) ? $clog2(LOSS_WINDOW) : 1;
  localparam int WERR_W = $clog2(LOSS_THRESH + 1);

  localparam logic [7:0]        c_lock_cnt    = 8'(LOCK_COUNT);
  localparam logic [WIN_W-1:0]  c_win_last    = WIN_W'(LOSS_WINDOW - 1);
  localparam logic [WERR_W-1:0] c_loss_thresh = WERR_W'(LOSS_THRESH);

  localparam logic [0:0] S_SEARCH = 1'b0;
  localparam logic [0:0] S_LOCKED = 1'b1;

  logic [0:0]        r_state;
  logic [0:0]        w_state_next;
  logic [30:0]       r_hist;
  logic [4:0]        r_fill;
  logic [7:0]        r_match;
  logic [WIN_W-1:0]  r_win;
  logic [WERR_W-1:0] r_werr;
  logic              r_err_pulse;
  logic [ERR_W-1:0]  r_err_count;
  logic [BIT_W-1:0]  r_bit_count;

  logic              w_pred;
  logic              w_mismatch;
  logic              w_match_hit;
  logic [7:0]        w_match_next;
  logic [WERR_W-1:0] w_werr_incl;
  logic              w_lock_hit;
  logic              w_lose;
  logic              w_chk_bit;

  // hist[0] is the newest bit, so the tap pair realises bit(n-28) ^ bit(n-31)
  assign w_pred       = r_hist[27] ^ r_hist[30];
  assign w_mismatch   = bus.din ^ w_pred;
  assign w_match_hit  = (r_fill == 5'd31) && (r_hist != 31'd0) && !w_mismatch;
  assign w_match_next = w_match_hit ? (r_match + 8'd1) : 8'd0;
  assign w_werr_incl  = r_werr + WERR_W'(w_mismatch);
  assign w_lock_hit   = (r_state == S_SEARCH) && bus.din_valid && w_match_hit &&
                        (w_match_next == c_lock_cnt);
  assign w_chk_bit    = (r_state == S_LOCKED) && bus.din_valid;
  assign w_lose       = w_chk_bit && (w_werr_incl >= c_loss_thresh);

  // State register
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) r_state <= S_SEARCH;
    else       r_state <= w_state_next;
  end

  // Next-state logic
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_SEARCH: if (w_lock_hit) w_state_next = S_LOCKED;
      S_LOCKED: if (w_lose)     w_state_next = S_SEARCH;
      default:                  w_state_next = S_SEARCH;
    endcase
  end

  // Outputs
  always_comb begin
    bus.locked    = (r_state == S_LOCKED);
    bus.err_pulse = r_err_pulse;
    bus.err_count = r_err_count;
    bus.bit_count = r_bit_count;
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      r_hist      <= '0;
      r_fill      <= '0;
      r_match     <= '0;
      r_win       <= '0;
      r_werr      <= '0;
      r_err_pulse <= 1'b0;
    end else begin
      r_err_pulse <= 1'b0;
      if (bus.din_valid) begin
        if (r_state == S_SEARCH) begin
          r_hist  <= {r_hist[29:0], bus.din};
          r_match <= w_match_next;
          if (r_fill != 5'd31) r_fill <= r_fill + 5'd1;
        end else begin
          // Locked: the local LFSR free-runs so line errors never reach hist
          r_hist      <= {r_hist[29:0], w_pred};
          r_err_pulse <= w_mismatch;
          if (w_lose) begin
            r_fill  <= '0;
            r_match <= '0;
            r_win   <= '0;
            r_werr  <= '0;
          end else begin
            r_win  <= r_win + WIN_W'(1);
            r_werr <= (r_win == c_win_last) ? '0 : w_werr_incl;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      r_err_count <= '0;
      r_bit_count <= '0;
    end else if (bus.clr_cnt) begin
      r_err_count <= '0;
      r_bit_count <= '0;
    end else if (w_chk_bit) begin
      if (r_bit_count != '1)               r_bit_count <= r_bit_count + BIT_W'(1);
      if (w_mismatch && r_err_count != '1) r_err_count <= r_err_count + ERR_W'(1);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_prbs31_checker.sv
`default_nettype none
// ============================================================================
// Module   : tb_prbs31_checker
// Brief    : Randomised self-checking bench for prbs31_checker against a
//            behavioural bit-queue model.
// Revision : 1.0
// ============================================================================
module tb_prbs31_checker;

  localparam int LOCK_COUNT  = 64;
  localparam int LOSS_WINDOW = 256;
  localparam int LOSS_THRESH = 8;
  localparam int ERR_W       = 4;
  localparam int BIT_W       = 32;
  localparam longint ERR_MAX = (64'd1 << ERR_W) - 1;
  localparam longint BIT_MAX = (64'd1 << BIT_W) - 1;

  logic clk;
  logic rst_n;

  prbs31_checker_if #(.ERR_W(ERR_W), .BIT_W(BIT_W)) bus ();

  prbs31_checker #(
    .LOCK_COUNT (LOCK_COUNT),
    .LOSS_WINDOW(LOSS_WINDOW),
    .LOSS_THRESH(LOSS_THRESH),
    .ERR_W      (ERR_W),
    .BIT_W      (BIT_W)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input longint got, input longint exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference stream: queue of the last 31 sequence bits, oldest first
  bit gq[$];

  task automatic reseed();
    gq.delete();
    for (int i = 0; i < 31; i++) gq.push_back(1'b0);
    gq[30] = 1'b1;
  endtask

  function automatic bit gen_bit();
    bit b;
    b = gq[gq.size()-28] ^ gq[gq.size()-31];
    gq.push_back(b);
    void'(gq.pop_front());
    return b;
  endfunction

  // Behavioural model of the checker
  bit     mh[$];
  bit     m_lock, m_pulse;
  int     m_fill, m_match, m_win, m_werr;
  longint m_err, m_bits;

  task automatic model_reset();
    mh.delete();
    for (int i = 0; i < 31; i++) mh.push_back(1'b0);
    m_lock = 0; m_pulse = 0;
    m_fill = 0; m_match = 0; m_win = 0; m_werr = 0;
    m_err = 0; m_bits = 0;
  endtask

  task automatic model_edge(input bit d, input bit v, input bit c);
    bit pred, mis, nz;
    pred = mh[mh.size()-28] ^ mh[mh.size()-31];
    mis  = d ^ pred;
    nz   = 0;
    foreach (mh[i]) if (mh[i]) nz = 1;
    m_pulse = 0;
    if (v) begin
      if (!m_lock) begin
        if (m_fill == 31 && nz && !mis) m_match++;
        else                            m_match = 0;
        mh.push_back(d);
        void'(mh.pop_front());
        if (m_fill < 31) m_fill++;
        if (m_match == LOCK_COUNT) m_lock = 1;
      end else begin
        mh.push_back(pred);
        void'(mh.pop_front());
        if (mis) begin
          m_pulse = 1;
          m_werr++;
          if (m_err < ERR_MAX) m_err++;
        end
        if (m_bits < BIT_MAX) m_bits++;
        if (m_werr >= LOSS_THRESH) begin
          m_lock = 0; m_fill = 0; m_match = 0; m_win = 0; m_werr = 0;
        end else begin
          m_win++;
          if (m_win == LOSS_WINDOW) begin
            m_win = 0;
            m_werr = 0;
          end
        end
      end
    end
    if (c) begin
      m_err  = 0;
      m_bits = 0;
    end
  endtask

  task automatic step(input bit d, input bit v, input bit c);
    @(negedge clk);
    bus.din = d; bus.din_valid = v; bus.clr_cnt = c;
    @(posedge clk);
    #1;
    model_edge(d, v, c);
    chk("locked",    bus.locked,    m_lock);
    chk("err_pulse", bus.err_pulse, m_pulse);
    chk("err_count", bus.err_count, m_err);
    chk("bit_count", bus.bit_count, m_bits);
  endtask

  task automatic async_reset();
    @(negedge clk);
    #2 rst_n = 1'b1;
    #1;
    model_reset();
    chk("async_rst_locked", bus.locked, 0);
    chk("async_rst_bits",   bus.bit_count, 0);
    @(negedge clk);
    rst_n = 1'b0;
  endtask

  int n_valid;
  int n_inj;
  bit b, inj, v;

  initial begin
    bus.din = 1'b0; bus.din_valid = 1'b0; bus.clr_cnt = 1'b0;
    rst_n = 1'b1;
    model_reset();
    reseed();

    // Reset hold with din toggling
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      bus.din = ~bus.din; bus.din_valid = 1'b1;
      @(posedge clk); #1;
      chk("rst_locked",    bus.locked,    0);
      chk("rst_err_pulse", bus.err_pulse, 0);
      chk("rst_err_count", bus.err_count, 0);
      chk("rst_bit_count", bus.bit_count, 0);
    end
    @(negedge clk);
    rst_n = 1'b0; bus.din_valid = 1'b0;

    // Clean lock on valid bit 95, then 1000 checked bits
    for (int i = 1; i <= 95; i++) begin
      step(gen_bit(), 1'b1, 1'b0);
      if (i == 94) chk("prelock_94", bus.locked, 0);
    end
    chk("lock_at_95", bus.locked, 1);
    for (int i = 0; i < 1000; i++) step(gen_bit(), 1'b1, 1'b0);
    chk("clean_err", bus.err_count, 0);
    chk("clean_bits", bus.bit_count, 1000);

    // Single error: one pulse, free-running prediction absorbs it
    step(~gen_bit(), 1'b1, 1'b0);
    chk("single_pulse", bus.err_pulse, 1);
    step(gen_bit(), 1'b1, 1'b0);
    chk("single_pulse_end", bus.err_pulse, 0);
    for (int i = 0; i < 200; i++) step(gen_bit(), 1'b1, 1'b0);
    chk("single_err", bus.err_count, 1);
    chk("single_lock", bus.locked, 1);

    // All-zero input never locks
    async_reset();
    for (int i = 0; i < 500; i++) step(1'b0, 1'b1, 1'b0);
    chk("zeros_nolock", bus.locked, 0);

    // Clean stream with 50% valid gaps: lock counts valid bits only
    async_reset();
    reseed();
    n_valid = 0;
    for (int i = 0; i < 1000 && !bus.locked; i++) begin
      v = 1'($urandom % 2);
      if (v) begin
        b = gen_bit();
        n_valid++;
      end else begin
        b = 1'($urandom % 2);
      end
      step(b, v, 1'b0);
    end
    chk("gap_lock_valid", n_valid, 95);

    // Loss of lock: 8 errors inside 100 bits, then relock
    n_inj = 0;
    for (int i = 0; i < 100 && n_inj < 8; i++) begin
      inj = (i % 12 == 0);
      step(gen_bit() ^ inj, 1'b1, 1'b0);
      if (inj) begin
        n_inj++;
        if (n_inj < 8) chk("loss_still_locked", bus.locked, 1);
      end
    end
    chk("loss_unlocked", bus.locked, 0);
    chk("loss_err", bus.err_count, 8);
    n_valid = 0;
    for (int i = 0; i < 400 && !bus.locked; i++) begin
      step(gen_bit(), 1'b1, 1'b0);
      n_valid++;
    end
    chk("relock_valid", n_valid, 95);

    // Saturation with spaced errors, gaps after some error bits
    step(gen_bit(), 1'b1, 1'b1);
    chk("clr_err", bus.err_count, 0);
    for (int e = 0; e < 20; e++) begin
      step(~gen_bit(), 1'b1, 1'b0);
      if (e % 3 == 0) step(1'($urandom % 2), 1'b0, 1'b0);
      for (int i = 0; i < 39; i++) step(gen_bit(), 1'b1, 1'b0);
    end
    chk("sat_err", bus.err_count, 15);
    chk("sat_lock", bus.locked, 1);

    // Clear coincident with an error wins
    step(~gen_bit(), 1'b1, 1'b1);
    chk("clr_vs_err", bus.err_count, 0);
    chk("clr_vs_err_pulse", bus.err_pulse, 1);
    for (int i = 0; i < 20; i++) step(gen_bit(), 1'b1, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire

// File: doc/prbs31_checker.md
Name: prbs31_checker

Overview:
- Serial PRBS31 receiver/checker (polynomial x^31 + x^28 + 1) that pairs with the team's PRBS31 generator on the far end of a serial link.
- Self-synchronises to the incoming bit stream, then free-runs a local LFSR and compares each received bit against the predicted bit.
- Reports lock status, per-bit error pulses and saturating error/bit counters for bring-up and BER measurement on the TT tile.

Parameters:
- LOCK_COUNT, 64, consecutive valid matches in SEARCH required to declare lock (1..255).
- LOSS_WINDOW, 256, window length in valid bits for loss-of-lock detection (power of 2, 2..65536).
- LOSS_THRESH, 8, errors within one window that force return to SEARCH (1..LOSS_WINDOW).
- ERR_W, 16, width of err_count.
- BIT_W, 32, width of bit_count.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  reset, asynchronous, active-high (the name notwithstanding).
- din  in  1  received serial bit.
- din_valid  in  1  din is sampled only on cycles where this is 1.
- clr_cnt  in  1  synchronous clear of err_count and bit_count.
- locked  out  1  high while the FSM is in LOCKED.
- err_pulse  out  1  one-cycle pulse, registered, flagging a mismatch in LOCKED.
- err_count  out  ERR_W  saturating count of mismatches seen while LOCKED.
- bit_count  out  BIT_W  saturating count of valid bits checked while LOCKED.

Behaviour:
- Reset: clock and reset are decided as reset rst_n, asynchronous, active-high; clock clk. While rst_n=1, the following are held at 0:
  - hist[30:0], fill counter, match counter, window counter and window error counter;
  - locked, err_pulse, err_count and bit_count.
  - The FSM is held in SEARCH.
- Prediction: pred = hist[27] ^ hist[30]. hist[0] holds the newest bit, so pred is bit(n-28) ^ bit(n-31).
- din_valid=0: no state changes, and err_pulse is driven to 0 on the next edge.
- SEARCH, on a valid bit:
  - The shift is hist <= {hist[29:0], din}.
  - fill saturates at 31.
  - A match is counted when fill==31, hist!=0 and din==pred. Any other case resets the match counter to 0; the all-zero history therefore never locks.
  - When a valid bit brings the match count to LOCK_COUNT, go to LOCKED. locked=1 on that same edge.
  - No errors are counted in SEARCH.
- LOCKED, on a valid bit:
  - The shift is hist <= {hist[29:0], pred}. The local LFSR free-runs, so a received error does not corrupt the prediction.
  - If din != pred: err_pulse=1 for one cycle (registered, visible the cycle after the bit is sampled), err_count increments, and the window error counter increments.
  - bit_count increments on every valid bit.
  - The window counter increments on every valid bit. On wrap after LOSS_WINDOW bits, the window error counter resets to 0.
  - If the window error count including the current bit reaches LOSS_THRESH: go to SEARCH. This clears locked, fill, the match count and both window counters; hist is retained but refilled from din.
- Counters saturate at all-ones and never wrap.
- clr_cnt has priority over a coincident increment: both counters become 0 on that edge. clr_cnt does not affect lock state or window counters.
- Reset mid-operation immediately returns every item listed under Reset to 0 and the FSM to SEARCH, regardless of the clock.

Test Plan:
1. Reset → hold rst_n=1 for 3 cycles with din toggling → locked=0, err_pulse=0, err_count=0, bit_count=0.
2. Clean lock → reference generator seeded to 1, feeding din_valid=1 continuously → locked rises on the edge sampling valid bit 95 (31 fill + 64 matches). Then run 1000 further bits → err_count=0, bit_count=1000.
3. Single error → in LOCKED, invert exactly one bit → err_pulse high for exactly one cycle, err_count=1, locked stays 1. The following bits produce no further errors, which proves the free-running prediction.
4. All-zero input and gaps → 500 valid zero bits → locked stays 0. Then a clean stream with din_valid toggling 50% → lock occurs after 95 valid bits, not after 95 cycles.
5. Loss of lock → in LOCKED, invert 8 bits within 100 bits → locked falls on the 8th error's edge, err_count=8. The clean stream then relocks after 95 further valid bits.
6. Clear and saturation → with ERR_W=4, inject 20 spaced errors → err_count=15. Assert clr_cnt on the same edge as an error → err_count=0.
